issue_scoreboard: RTL and testbench

- Issue controller between `decoder` and the execution units.
- Holds one decoded instruction and tracks pending destination registers in a 32-bit scoreboard.
- Stalls on RAW/WAW hazards or a busy target unit, then issues to exactly one unit.
- Drives the decoder's `i_busy` back-pressure and routes illegal instructions to a trap handshake.

---
 rtl/issue_scoreboard.sv | 222 ++++++++++++++++++++++
 tb/tb_issue_scoreboard.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_scoreboard.sv
// -----------------------------------------------------------------------------
// issue_scoreboard
//
// Issue controller sitting between the decoder and the execution units. It
// holds one decoded instruction, tracks destination registers that still have
// a write outstanding (a one-bit-per-register scoreboard), stalls on RAW/WAW
// hazards or a busy target unit, and issues to exactly one unit with a
// one-cycle registered strobe. Illegal instructions (or an out-of-range unit
// index) are diverted to a trap request/acknowledge handshake.
//
// Optional feature macro: SCOREBOARD_WB_BYPASS_EN
//   defined   : a writeback in the same cycle removes the hazard it resolves,
//               so the consumer issues the cycle the writeback lands.
//   undefined : hazards use the registered scoreboard only (one cycle later).
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   clk_en            global enable; all state holds and iss_valid is 0 when low
//   dec_*             decoded instruction fields from the decoder
//   dec_busy          back-pressure to the decoder (combinational)
//   unit_busy         per-unit busy inputs
//   iss_valid         one-hot issue strobe (registered, one cycle)
//   iss_rs1/rs2/rd    register fields of the issued instruction
//   iss_imm/iss_addr  immediate / address of the issued instruction
//   wb_valid, wb_rd   writeback completion, clears the scoreboard bit
//   flush             drop the held instruction (branch redirect)
//   trap_req/addr     illegal instruction pending, with its address
//   trap_ack          trap accepted by the handler
// -----------------------------------------------------------------------------
module issue_scoreboard #(
  parameter int N_UNITS    = 4,
  parameter int REG_ADDR_W = 5,
  parameter int XLEN       = 32,
  localparam int UNIT_W    = (N_UNITS > 1) ? $clog2(N_UNITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clk_en,
  input  logic                  dec_valid,
  input  logic [REG_ADDR_W-1:0] dec_rs1,
  input  logic [REG_ADDR_W-1:0] dec_rs2,
  input  logic [REG_ADDR_W-1:0] dec_rd,
  input  logic                  dec_use_rs1,
  input  logic                  dec_use_rs2,
  input  logic                  dec_wr_rd,
  input  logic [UNIT_W-1:0]     dec_unit,
  input  logic [XLEN-1:0]       dec_imm,
  input  logic [XLEN-1:0]       dec_addr,
  input  logic                  dec_illegal,
  output logic                  dec_busy,
  input  logic [N_UNITS-1:0]    unit_busy,
  output logic [N_UNITS-1:0]    iss_valid,
  output logic [REG_ADDR_W-1:0] iss_rs1,
  output logic [REG_ADDR_W-1:0] iss_rs2,
  output logic [REG_ADDR_W-1:0] iss_rd,
  output logic [XLEN-1:0]       iss_imm,
  output logic [XLEN-1:0]       iss_addr,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  flush,
  output logic                  trap_req,
  input  logic                  trap_ack,
  output logic [XLEN-1:0]       trap_addr
);

  localparam int N_REGS = 1 << REG_ADDR_W;

  typedef enum logic [1:0] {IDLE, HOLD, TRAP} state_t;

  state_t                state_q, state_d;
  logic [N_REGS-1:0]     pend_q, pend_d;

  // Held (latched) instruction
  logic [REG_ADDR_W-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic                  use_rs1_q, use_rs1_d, use_rs2_q, use_rs2_d;
  logic                  wr_rd_q, wr_rd_d;
  logic [UNIT_W-1:0]     unit_q, unit_d;
  logic [XLEN-1:0]       imm_q, imm_d, addr_q, addr_d;

  // Issue output registers; captured at issue so a back-to-back capture of the
  // next instruction cannot disturb the fields presented with the strobe.
  logic [N_UNITS-1:0]    iss_valid_q, iss_valid_d;
  logic [REG_ADDR_W-1:0] iss_rs1_q, iss_rs1_d, iss_rs2_q, iss_rs2_d;
  logic [REG_ADDR_W-1:0] iss_rd_q, iss_rd_d;
  logic [XLEN-1:0]       iss_imm_q, iss_imm_d, iss_addr_q, iss_addr_d;

  logic [N_REGS-1:0]     blk_pend;
  logic [(1<<UNIT_W)-1:0] unit_legal;
  logic                  hazard, issue_ok, do_issue, accept, illegal_in;

  // Hazard / issue evaluation
  always_comb begin
    blk_pend = pend_q;
`ifdef SCOREBOARD_WB_BYPASS_EN
    // A writeback landing this cycle already resolves its hazard.
    if (wb_valid) blk_pend[wb_rd] = 1'b0;
`endif
    hazard   = (use_rs1_q & blk_pend[rs1_q]) |
               (use_rs2_q & blk_pend[rs2_q]) |
               (wr_rd_q   & blk_pend[rd_q]);
    issue_ok = (state_q == HOLD) & ~hazard & ~unit_busy[unit_q];
    dec_busy = ((state_q == HOLD) & ~issue_ok) | (state_q == TRAP);
    do_issue = clk_en & issue_ok & ~flush;
    accept   = clk_en & dec_valid & ~dec_busy & ~flush;

    // Unit indices that do not map onto an execution unit trap like illegals.
    for (int i = 0; i < (1 << UNIT_W); i++) unit_legal[i] = (i < N_UNITS);
    illegal_in = dec_illegal | ~unit_legal[dec_unit];
  end

  // Next-state, scoreboard and held-field update
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rd_d        = rd_q;
    use_rs1_d   = use_rs1_q;
    use_rs2_d   = use_rs2_q;
    wr_rd_d     = wr_rd_q;
    unit_d      = unit_q;
    imm_d       = imm_q;
    addr_d      = addr_q;
    iss_valid_d = '0;
    iss_rs1_d   = iss_rs1_q;
    iss_rs2_d   = iss_rs2_q;
    iss_rd_d    = iss_rd_q;
    iss_imm_d   = iss_imm_q;
    iss_addr_d  = iss_addr_q;

    if (clk_en) begin
      if (wb_valid) pend_d[wb_rd] = 1'b0;

      // Set after clear: a new producer wins over a completing one.
      if (do_issue) begin
        iss_valid_d[unit_q] = 1'b1;
        iss_rs1_d           = rs1_q;
        iss_rs2_d           = rs2_q;
        iss_rd_d            = rd_q;
        iss_imm_d           = imm_q;
        iss_addr_d          = addr_q;
        if (wr_rd_q) pend_d[rd_q] = 1'b1;
      end
      pend_d[0] = 1'b0;

      case (state_q)
        IDLE, HOLD: begin
          if (flush) begin
            state_d = IDLE;
          end else if (accept) begin
            rs1_d     = dec_rs1;
            rs2_d     = dec_rs2;
            rd_d      = dec_rd;
            use_rs1_d = dec_use_rs1;
            use_rs2_d = dec_use_rs2;
            wr_rd_d   = dec_wr_rd;
            unit_d    = dec_unit;
            imm_d     = dec_imm;
            addr_d    = dec_addr;
            state_d   = illegal_in ? TRAP : HOLD;
          end else if (do_issue) begin
            state_d = IDLE;
          end
        end
        TRAP: begin
          if (flush || trap_ack) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pend_q      <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      use_rs1_q   <= 1'b0;
      use_rs2_q   <= 1'b0;
      wr_rd_q     <= 1'b0;
      unit_q      <= '0;
      imm_q       <= '0;
      addr_q      <= '0;
      iss_valid_q <= '0;
      iss_rs1_q   <= '0;
      iss_rs2_q   <= '0;
      iss_rd_q    <= '0;
      iss_imm_q   <= '0;
      iss_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      use_rs1_q   <= use_rs1_d;
      use_rs2_q   <= use_rs2_d;
      wr_rd_q     <= wr_rd_d;
      unit_q      <= unit_d;
      imm_q       <= imm_d;
      addr_q      <= addr_d;
      iss_valid_q <= iss_valid_d;
      iss_rs1_q   <= iss_rs1_d;
      iss_rs2_q   <= iss_rs2_d;
      iss_rd_q    <= iss_rd_d;
      iss_imm_q   <= iss_imm_d;
      iss_addr_q  <= iss_addr_d;
    end
  end

  assign iss_valid = clk_en ? iss_valid_q : '0;
  assign iss_rs1   = iss_rs1_q;
  assign iss_rs2   = iss_rs2_q;
  assign iss_rd    = iss_rd_q;
  assign iss_imm   = iss_imm_q;
  assign iss_addr  = iss_addr_q;
  assign trap_req  = (state_q == TRAP);
  assign trap_addr = trap_req ? addr_q : '0;

endmodule

// File: tb/tb_issue_scoreboard.sv
module tb_issue_scoreboard;

`ifdef SCOREBOARD_WB_BYPASS_EN
  localparam int WB_LAT = 1;
`else
  localparam int WB_LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst_n, clk_en, dec_valid;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd, wb_rd;
  logic        dec_use_rs1, dec_use_rs2, dec_wr_rd, dec_illegal;
  logic [1:0]  dec_unit;
  logic [31:0] dec_imm, dec_addr;
  logic        dec_busy;
  logic [3:0]  unit_busy, iss_valid;
  logic [4:0]  iss_rs1, iss_rs2, iss_rd;
  logic [31:0] iss_imm, iss_addr, trap_addr;
  logic        wb_valid, flush, trap_req, trap_ack;

  issue_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .dec_valid(dec_valid),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
    .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2), .dec_wr_rd(dec_wr_rd),
    .dec_unit(dec_unit), .dec_imm(dec_imm), .dec_addr(dec_addr),
    .dec_illegal(dec_illegal), .dec_busy(dec_busy), .unit_busy(unit_busy),
    .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
    .iss_imm(iss_imm), .iss_addr(iss_addr), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .flush(flush), .trap_req(trap_req), .trap_ack(trap_ack), .trap_addr(trap_addr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0]  v;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm, addr;
    int          at;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] trap_q[$];
  logic        trap_prev = 1'b0;

  // Monitor: every issue strobe and every trap entry is checked against the
  // next expectation queued by the stimulus.
  always @(negedge clk) begin
    if (rst_n) begin
      if (iss_valid != 4'b0) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL issue_unexpected cyc=%0d got v=%b rd=%0d want none", cyc, iss_valid, iss_rd);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (iss_valid !== e.v || iss_rs1 !== e.rs1 || iss_rs2 !== e.rs2 || iss_rd !== e.rd ||
              iss_imm !== e.imm || iss_addr !== e.addr || cyc != e.at) begin
            bad++;
            $display("FAIL issue cyc=%0d got v=%b rs1=%0d rs2=%0d rd=%0d imm=%h addr=%h want cyc=%0d v=%b rs1=%0d rs2=%0d rd=%0d imm=%h addr=%h",
                     cyc, iss_valid, iss_rs1, iss_rs2, iss_rd, iss_imm, iss_addr,
                     e.at, e.v, e.rs1, e.rs2, e.rd, e.imm, e.addr);
          end
        end
      end
      if (trap_req && !trap_prev) begin
        total++;
        if (trap_q.size() == 0) begin
          bad++;
          $display("FAIL trap_unexpected cyc=%0d got addr=%h want none", cyc, trap_addr);
        end else begin
          logic [31:0] ta;
          ta = trap_q.pop_front();
          if (trap_addr !== ta) begin
            bad++;
            $display("FAIL trap_addr got=%h want=%h", trap_addr, ta);
          end
        end
      end
    end
    trap_prev <= trap_req & rst_n;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] v, input logic [4:0] rs1, rs2, rd,
                      input logic [31:0] imm, addr, input int at);
    exp_t e;
    e.v = v; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.imm = imm; e.addr = addr; e.at = at;
    exp_q.push_back(e);
  endtask

  // Present one instruction; returns the cycle number of the capture cycle.
  task automatic present(input logic [4:0] rs1, rs2, rd, input logic u1, u2, wr,
                         input logic [1:0] unit, input logic [31:0] imm, addr,
                         input logic ill, output int cap);
    dec_rs1 = rs1; dec_rs2 = rs2; dec_rd = rd;
    dec_use_rs1 = u1; dec_use_rs2 = u2; dec_wr_rd = wr;
    dec_unit = unit; dec_imm = imm; dec_addr = addr; dec_illegal = ill;
    dec_valid = 1'b1;
    cap = -1;
    for (int i = 0; i < 50 && cap < 0; i++) begin
      @(negedge clk);
      if (!dec_busy) cap = cyc;
      step();
    end
    dec_valid = 1'b0;
    if (cap < 0) chk("accept_timeout", 32'd1, 32'd0);
  endtask

  task automatic wb(input logic [4:0] r, output int w);
    wb_valid = 1'b1;
    wb_rd    = r;
    w        = cyc;
    step();
    wb_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, c2, w, f;
    rst_n = 1'b0; clk_en = 1'b1; dec_valid = 1'b0;
    dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0; dec_use_rs1 = 1'b0; dec_use_rs2 = 1'b0;
    dec_wr_rd = 1'b0; dec_unit = '0; dec_imm = '0; dec_addr = '0; dec_illegal = 1'b0;
    unit_busy = '0; wb_valid = 1'b0; wb_rd = '0; flush = 1'b0; trap_ack = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_iss_valid", {28'd0, iss_valid}, 32'd0);
    chk("rst_dec_busy",  {31'd0, dec_busy}, 32'd0);
    chk("rst_trap_req",  {31'd0, trap_req}, 32'd0);
    chk("rst_trap_addr", trap_addr, 32'd0);
    chk("rst_iss_rd",    {27'd0, iss_rd}, 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // ADD x3,x1,x2 then ADD x4,x3,x0 back-to-back: RAW on x3 until writeback
    present(5'd1, 5'd2, 5'd3, 1, 1, 1, 2'd0, 32'h11, 32'h100, 0, c);
    push(4'b0001, 5'd1, 5'd2, 5'd3, 32'h11, 32'h100, c + 2);
    present(5'd3, 5'd0, 5'd4, 1, 1, 1, 2'd0, 32'h22, 32'h104, 0, c2);
    chk("b2b_accept_cycle", c2, c + 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("raw_x3_busy", {31'd0, dec_busy}, 32'd1);
      step();
    end
    wb(5'd3, w);
    push(4'b0001, 5'd3, 5'd0, 5'd4, 32'h22, 32'h104, w + WB_LAT);

    // MUL x7,x5,x6 with MULDIV busy, then SUB x9,x7 waits on pend[7]
    unit_busy = 4'b0010;
    present(5'd5, 5'd6, 5'd7, 1, 1, 1, 2'd1, 32'h33, 32'h108, 0, c);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("unit_busy_stall", {31'd0, dec_busy}, 32'd1);
      step();
    end
    unit_busy = 4'b0000;
    f = cyc;
    push(4'b0010, 5'd5, 5'd6, 5'd7, 32'h33, 32'h108, f + 1);
    present(5'd7, 5'd0, 5'd9, 1, 1, 1, 2'd0, 32'h44, 32'h10c, 0, c);
    chk("sub_accept_cycle", c, f);
    @(negedge clk);
    chk("raw_x7_busy", {31'd0, dec_busy}, 32'd1);
    step();
    wb(5'd7, w);
    push(4'b0001, 5'd7, 5'd0, 5'd9, 32'h44, 32'h10c, w + WB_LAT);

    // ADDI x0 then ADD x11,x0,x0: x0 never pending, full throughput
    present(5'd0, 5'd0, 5'd0, 1, 0, 1, 2'd0, 32'h55, 32'h110, 0, c);
    push(4'b0001, 5'd0, 5'd0, 5'd0, 32'h55, 32'h110, c + 2);
    present(5'd0, 5'd0, 5'd11, 1, 1, 1, 2'd0, 32'h66, 32'h114, 0, c2);
    chk("x0_no_stall_cycle", c2, c + 1);
    push(4'b0001, 5'd0, 5'd0, 5'd11, 32'h66, 32'h114, c + 3);

    // Illegal at 0x40: trap until trap_ack, no issue
    present(5'd1, 5'd2, 5'd12, 1, 1, 1, 2'd0, 32'h77, 32'h40, 1, c);
    trap_q.push_back(32'h40);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("trap_busy", {31'd0, dec_busy}, 32'd1);
      chk("trap_req_held", {31'd0, trap_req}, 32'd1);
      chk("trap_addr_held", trap_addr, 32'h40);
      step();
    end
    trap_ack = 1'b1;
    step();
    trap_ack = 1'b0;
    @(negedge clk);
    chk("trap_ack_release", {31'd0, trap_req}, 32'd0);
    chk("trap_ack_busy", {31'd0, dec_busy}, 32'd0);
    step();

    // Flush while in TRAP
    present(5'd0, 5'd0, 5'd0, 0, 0, 0, 2'd2, 32'h0, 32'h80, 1, c);
    trap_q.push_back(32'h80);
    @(negedge clk);
    chk("trap2_req", {31'd0, trap_req}, 32'd1);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("trap_flush_drop", {31'd0, trap_req}, 32'd0);
    step();

    // Stall on pend[4], flush drops it; wb x4 clears; later reader of x4 issues
    present(5'd4, 5'd0, 5'd12, 1, 1, 1, 2'd0, 32'h88, 32'h118, 0, c);
    @(negedge clk);
    chk("raw_x4_busy", {31'd0, dec_busy}, 32'd1);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_idle_busy", {31'd0, dec_busy}, 32'd0);
    step();
    wb(5'd4, w);
    present(5'd4, 5'd0, 5'd13, 1, 1, 1, 2'd0, 32'h99, 32'h11c, 0, c);
    push(4'b0001, 5'd4, 5'd0, 5'd13, 32'h99, 32'h11c, c + 2);
    for (int i = 0; i < 3; i++) step();

    // clk_en low: a presented instruction is not captured
    clk_en = 1'b0;
    dec_rs1 = 5'd1; dec_rs2 = 5'd2; dec_rd = 5'd20; dec_use_rs1 = 1'b1;
    dec_use_rs2 = 1'b1; dec_wr_rd = 1'b1; dec_unit = 2'd0; dec_illegal = 1'b0;
    dec_imm = 32'hAA; dec_addr = 32'h200; dec_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("clken_idle_busy", {31'd0, dec_busy}, 32'd0);
      step();
    end
    dec_valid = 1'b0;
    clk_en = 1'b1;
    step();
    @(negedge clk);
    chk("clken_no_capture", {31'd0, dec_busy}, 32'd0);
    step();

    // Async reset mid-HOLD clears everything
    present(5'd13, 5'd0, 5'd15, 1, 1, 1, 2'd0, 32'hBB, 32'h120, 0, c);
    @(negedge clk);
    chk("raw_x13_busy", {31'd0, dec_busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", {31'd0, dec_busy}, 32'd0);
    chk("async_rst_iss_rd", {27'd0, iss_rd}, 32'd0);
    chk("async_rst_iss_imm", iss_imm, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    present(5'd13, 5'd9, 5'd16, 1, 1, 1, 2'd3, 32'hCC, 32'h124, 0, c);
    push(4'b1000, 5'd13, 5'd9, 5'd16, 32'hCC, 32'h124, c + 2);

    for (int i = 0; i < 6; i++) step();
    chk("issues_drained", exp_q.size(), 32'd0);
    chk("traps_drained", trap_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
